ysyx_23060236_rd_arbiter: RTL and testbench
===========================================

Name: ysyx_23060236_rd_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 read master port between the IFU (burst-capable) and the LSU (single-beat).
- Registers the winning AR request, owns the port until the burst completes and routes R beats back to the winner.
- Generates rlast locally from a beat counter and flags downstream ID/last mismatches.
- Sits between the IFU/LSU read channels and the xbar's SoC read port; it replaces fixed-priority read arbitration.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- m0_araddr  in  ADDR_W  IFU read address
- m0_arvalid  in  1  IFU AR valid
- m0_arready  out  1  IFU AR accepted
- m0_arlen  in  4  IFU burst length minus 1
- m0_arburst  in  2  IFU burst type
- m0_arsize  in  3  IFU beat size
- m0_rdata  out  DATA_W  IFU read data
- m0_rresp  out  2  IFU read response
- m0_rlast  out  1  IFU last beat
- m0_rvalid  out  1  IFU R valid
- m0_rready  in  1  IFU R ready
- m1_araddr  in  ADDR_W  LSU read address
- m1_arvalid  in  1  LSU AR valid
- m1_arready  out  1  LSU AR accepted
- m1_arsize  in  3  LSU beat size
- m1_rdata  out  DATA_W  LSU read data
- m1_rresp  out  2  LSU read response
- m1_rvalid  out  1  LSU R valid
- m1_rready  in  1  LSU R ready
- s_araddr  out  ADDR_W  downstream address
- s_arvalid  out  1  downstream AR valid
- s_arready  in  1  downstream AR ready
- s_arid  out  4  0 for m0, 1 for m1
- s_arlen  out  8  {4'b0, latched len}
- s_arsize  out  3  latched size
- s_arburst  out  2  latched burst (m1: 2'b00)
- s_rdata  in  DATA_W  downstream data
- s_rresp  in  2  downstream response
- s_rlast  in  1  downstream last
- s_rid  in  4  downstream ID
- s_rvalid  in  1  downstream R valid
- s_rready  out  1  downstream R ready
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky mismatch flag

Behaviour:
- Reset: the asynchronous, active-high reset forces state=IDLE, last_grant=1, beat_cnt=0, protocol_err=0, latched fields=0.
  - All outputs read 0 while reset is high.
  - Reset asserted mid-burst abandons the transaction with no further handshakes.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Only m0 valid: grant m0. Only m1 valid: grant m1.
  - Both valid: grant the requester != last_grant.
  - The winner's arready=1 combinationally in that cycle. The loser's arready=0.
  - Latch addr, len (m1: 0), size, burst, id → ADDR.
  - No request: stay in IDLE.
- ADDR:
  - s_arvalid=1. Latched fields are held stable.
  - Both m*_arready=0.
  - On s_arready: → DATA, beat_cnt=0.
- DATA:
  - s_rready = granted rready.
  - Granted rvalid = s_rvalid; granted rdata/rresp = s_rdata/s_rresp.
  - Non-granted rvalid/rdata/rresp = 0.
  - m0_rlast = granted m0 & (beat_cnt==len).
  - On beat handshake (s_rvalid & s_rready):
    - If beat_cnt==len: → IDLE, last_grant=granted.
    - Else: beat_cnt+1.
  - Neither party holding rvalid/rready stalls the state indefinitely, with no timeout.
- protocol_err is set on any beat handshake where s_rlast != (beat_cnt==len) or s_rid != latched id.
  - It is cleared only by reset.
  - The local count still terminates the burst.
- beat_cnt is 4 bits and never wraps; the maximum len is 15.
- Latency:
  - arvalid → s_arvalid: 1 cycle.
  - Final R handshake → IDLE in the next cycle; a new grant is possible in that cycle, giving a 1-cycle bubble.
- Outside IDLE, a requester's arvalid is ignored (arready=0) and it must keep arvalid high.

Test Plan:
- Single m0 request, addr 0x3000_0000, len=3, downstream returns 4 beats with rlast on the 4th → s_arvalid one cycle after the grant, s_arid=0, s_arlen=3; m0 sees 4 beats; m0_rlast only on beat 4; busy falls after beat 4.
- m0 and m1 valid in the same cycle after reset → m0 granted first (last_grant=1); m1 granted in the cycle IDLE resumes; s_arid sequence 0 then 1.
- m0 held continuously valid and m1 asserted during an m0 burst → the next grant goes to m1, then m0; no requester is served twice consecutively while the other waits.
- Downstream asserts s_rlast on beat 2 of a len=3 burst → protocol_err=1 and stays 1; the burst still ends after 4 local beats.
- rready dropped for 5 cycles mid-burst with s_rvalid high → s_rready=0, beat_cnt holds, no beat is lost.
- reset asserted during DATA → outputs 0 immediately (asynchronous); after release, state is IDLE and a fresh m1 request completes with s_arid=1.

Source files
------------

// File: rtl/ysyx_23060236_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_rd_arbiter
//
// Round-robin read arbiter that shares one AXI4 read master port between the
// IFU (m0, burst-capable) and the LSU (m1, single-beat).
//
// The winning AR request is registered, and the winner keeps the downstream
// port until its burst completes. R beats are routed back to the winner only.
// The last-beat indication is produced locally from a beat counter. Any
// downstream rlast/rid disagreement sets a sticky protocol_err flag.
//
// Ports
//   clock, reset          : system clock, asynchronous active-high reset
//   m0_ar* / m0_r*        : IFU read address / read data channels
//   m1_ar* / m1_r*        : LSU read address / read data channels (no rlast)
//   s_ar* / s_r*          : downstream (xbar SoC) read port
//   busy                  : arbiter is not idle
//   protocol_err          : sticky downstream rlast/rid mismatch flag
// ---------------------------------------------------------------------------
module ysyx_23060236_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [3:0]        m0_arlen,
  input  logic [1:0]        m0_arburst,
  input  logic [2:0]        m0_arsize,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // LSU
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [2:0]        m1_arsize,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // Downstream
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  input  logic              s_rvalid,
  output logic              s_rready,
  // Status
  output logic              busy,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;  // 0: m0, 1: m1
  logic              grant_reg, grant_next;            // doubles as the latched id
  logic [3:0]        beat_cnt_reg, beat_cnt_next;
  logic [3:0]        len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [2:0]        size_reg, size_next;
  logic [1:0]        burst_reg, burst_next;
  logic              perr_reg, perr_next;

  logic              m0_arready_int, m1_arready_int;
  logic              s_rready_int;
  logic              pick_m1;
  logic              is_last;
  logic              r_hs;
  logic              in_data;

  // m1 wins when it is the only requester, or when both request and m0 was
  // served last. This alternates strictly under continuous contention.
  assign pick_m1 = m1_arvalid & (~m0_arvalid | ~last_grant_reg);
  assign is_last = (beat_cnt_reg == len_reg);
  assign in_data = (state_reg == DATA);
  assign r_hs    = in_data & s_rvalid & s_rready_int;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      beat_cnt_reg   <= 4'd0;
      len_reg        <= 4'd0;
      addr_reg       <= '0;
      size_reg       <= 3'd0;
      burst_reg      <= 2'd0;
      perr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      len_reg        <= len_next;
      addr_reg       <= addr_next;
      size_reg       <= size_next;
      burst_reg      <= burst_next;
      perr_reg       <= perr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    len_next        = len_reg;
    addr_next       = addr_reg;
    size_next       = size_reg;
    burst_next      = burst_reg;
    perr_next       = perr_reg;
    m0_arready_int  = 1'b0;
    m1_arready_int  = 1'b0;
    s_arvalid       = 1'b0;
    s_rready_int    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          m0_arready_int = ~pick_m1;
          m1_arready_int = pick_m1;
          grant_next     = pick_m1;
          state_next     = ADDR;
          if (pick_m1) begin
            addr_next  = m1_araddr;
            len_next   = 4'd0;
            size_next  = m1_arsize;
            burst_next = 2'b00;
          end else begin
            addr_next  = m0_araddr;
            len_next   = m0_arlen;
            size_next  = m0_arsize;
            burst_next = m0_arburst;
          end
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          state_next    = DATA;
          beat_cnt_next = 4'd0;
        end
      end
      DATA: begin
        s_rready_int = grant_reg ? m1_rready : m0_rready;
        if (r_hs) begin
          // The downstream rlast/rid are only checked; the local count
          // decides where the burst ends.
          if ((s_rlast != is_last) || (s_rid != {3'b000, grant_reg})) begin
            perr_next = 1'b1;
          end
          if (is_last) begin
            state_next      = IDLE;
            last_grant_next = grant_reg;
          end else begin
            beat_cnt_next = beat_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // arready depends combinationally on arvalid in IDLE, so it is forced low
  // while reset is held. Everything else derives from reset-cleared state.
  assign m0_arready = m0_arready_int & ~reset;
  assign m1_arready = m1_arready_int & ~reset;
  assign s_rready   = s_rready_int;

  assign s_araddr   = addr_reg;
  assign s_arid     = {3'b000, grant_reg};
  assign s_arlen    = {4'b0000, len_reg};
  assign s_arsize   = size_reg;
  assign s_arburst  = burst_reg;

  assign m0_rvalid  = in_data & ~grant_reg & s_rvalid;
  assign m0_rdata   = (in_data & ~grant_reg) ? s_rdata : '0;
  assign m0_rresp   = (in_data & ~grant_reg) ? s_rresp : 2'b00;
  assign m0_rlast   = in_data & ~grant_reg & is_last;

  assign m1_rvalid  = in_data & grant_reg & s_rvalid;
  assign m1_rdata   = (in_data & grant_reg) ? s_rdata : '0;
  assign m1_rresp   = (in_data & grant_reg) ? s_rresp : 2'b00;

  assign busy         = (state_reg != IDLE);
  assign protocol_err = perr_reg;

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060236_rd_arbiter.
// Drivers for both requesters and a downstream memory model run per cycle.
// A monitor predicts each grant with a round-robin model, queues the
// expected AR and R beats, and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_rd_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] m0_araddr;
  logic        m0_arvalid, m0_arready;
  logic [3:0]  m0_arlen;
  logic [1:0]  m0_arburst;
  logic [2:0]  m0_arsize;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rlast, m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;
  logic        m1_arvalid, m1_arready;
  logic [2:0]  m1_arsize;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid, m1_rready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        s_rvalid, s_rready;
  logic        busy, protocol_err;

  ysyx_23060236_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_arlen(m0_arlen), .m0_arburst(m0_arburst), .m0_arsize(m0_arsize),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_arsize(m1_arsize), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .protocol_err(protocol_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  req_t  q0[$], q1[$];
  ar_t   ar_q[$];
  beat_t rq0[$], rq1[$];
  logic [3:0] ar_ids[$];

  int    n_pass = 0;
  int    n_total = 0;
  int    stall0 = 0;
  bit    force_rvalid = 0;
  bit    early_mode = 0;
  int    m0_beats = 0;
  int    cyc = 0;
  int    grant_cyc = 0;

  // Memory contents seen by the downstream model, per beat.
  function automatic logic [31:0] mem_word(input logic [31:0] addr, input logic [3:0] beat);
    return (addr + {26'd0, beat, 2'b00}) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- m0 driver ----------------
  initial begin
    bit hs;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arburst = 0; m0_arsize = 0; m0_rready = 0;
    forever begin
      @(negedge clock);
      hs = m0_arvalid & m0_arready;
      @(posedge clock); #1;
      if (reset) begin
        q0.delete(); m0_arvalid = 0; m0_rready = 0;
      end else begin
        if (hs) void'(q0.pop_front());
        if (q0.size() > 0) begin
          m0_arvalid = 1; m0_araddr = q0[0].addr; m0_arlen = q0[0].len;
          m0_arsize = q0[0].size; m0_arburst = q0[0].burst;
        end else m0_arvalid = 0;
        if (stall0 > 0) begin m0_rready = 0; stall0--; end
        else m0_rready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- m1 driver ----------------
  initial begin
    bit hs;
    m1_arvalid = 0; m1_araddr = 0; m1_arsize = 0; m1_rready = 0;
    forever begin
      @(negedge clock);
      hs = m1_arvalid & m1_arready;
      @(posedge clock); #1;
      if (reset) begin
        q1.delete(); m1_arvalid = 0; m1_rready = 0;
      end else begin
        if (hs) void'(q1.pop_front());
        if (q1.size() > 0) begin
          m1_arvalid = 1; m1_araddr = q1[0].addr; m1_arsize = q1[0].size;
        end else m1_arvalid = 0;
        m1_rready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- downstream memory model ----------------
  initial begin
    bit ar_hs, r_hs, sl_busy;
    logic [3:0]  sl_id, sl_len, sl_beat;
    logic [31:0] sl_addr;
    sl_busy = 0; sl_id = 0; sl_len = 0; sl_beat = 0; sl_addr = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    forever begin
      @(negedge clock);
      ar_hs = s_arvalid & s_arready;
      r_hs  = s_rvalid & s_rready;
      @(posedge clock); #1;
      if (reset) begin
        sl_busy = 0; s_arready = 0; s_rvalid = 0;
      end else begin
        if (ar_hs) begin
          sl_busy = 1; sl_id = s_arid; sl_len = s_arlen[3:0]; sl_addr = s_araddr; sl_beat = 0;
        end
        if (r_hs) begin
          if (sl_beat == sl_len) sl_busy = 0;
          else sl_beat = sl_beat + 4'd1;
        end
        s_arready = !sl_busy && ($urandom_range(0, 1) == 1);
        if (sl_busy) begin
          if (!(s_rvalid && !r_hs)) s_rvalid = force_rvalid || ($urandom_range(0, 9) < 7);
        end else s_rvalid = 0;
        s_rdata = mem_word(sl_addr, sl_beat);
        s_rresp = sl_beat[1:0];
        s_rid   = sl_id;
        s_rlast = early_mode ? (sl_beat == 4'd1) : (sl_beat == sl_len);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit    model_last, cur, exp_g, perr_model, chk_idle, prev_sarv, exp_last;
    ar_t   a, e;
    beat_t b;
    model_last = 1; cur = 0; perr_model = 0; chk_idle = 0; prev_sarv = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        ar_q.delete(); rq0.delete(); rq1.delete();
        model_last = 1; perr_model = 0; chk_idle = 0; prev_sarv = 0;
      end else begin
        if (chk_idle) begin
          check("busy_fall", {31'd0, busy}, 32'd0);
          chk_idle = 0;
        end
        if (s_arvalid && !prev_sarv) check("ar_latency", cyc - grant_cyc, 32'd1);
        prev_sarv = s_arvalid;

        if ((m0_arvalid & m0_arready) | (m1_arvalid & m1_arready)) begin
          exp_g = (m0_arvalid && m1_arvalid) ? !model_last : m1_arvalid;
          check("grant", {30'd0, m1_arready, m0_arready}, exp_g ? 32'd2 : 32'd1);
          model_last = exp_g; cur = exp_g; grant_cyc = cyc;
          if (exp_g) begin
            a.id = 4'd1; a.addr = m1_araddr; a.len = 8'd0; a.size = m1_arsize; a.burst = 2'b00;
          end else begin
            a.id = 4'd0; a.addr = m0_araddr; a.len = {4'd0, m0_arlen}; a.size = m0_arsize; a.burst = m0_arburst;
          end
          ar_q.push_back(a);
          for (int i = 0; i <= int'(a.len); i++) begin
            b.data = mem_word(a.addr, 4'(i));
            b.resp = 2'(i);
            b.last = (i == int'(a.len));
            if (exp_g) rq1.push_back(b); else rq0.push_back(b);
          end
        end

        if (s_arvalid & s_arready) begin
          if (ar_q.size() == 0) check("ar_unexpected", 32'd1, 32'd0);
          else begin
            e = ar_q.pop_front();
            $display("AR id=%0d addr=%h len=%0d size=%0d burst=%0d", s_arid, s_araddr, s_arlen, s_arsize, s_arburst);
            check("ar_id", {28'd0, s_arid}, {28'd0, e.id});
            check("ar_addr", s_araddr, e.addr);
            check("ar_len", {24'd0, s_arlen}, {24'd0, e.len});
            check("ar_size", {29'd0, s_arsize}, {29'd0, e.size});
            check("ar_burst", {30'd0, s_arburst}, {30'd0, e.burst});
            ar_ids.push_back(s_arid);
          end
        end

        if (s_rvalid & s_rready) begin
          check("perr", {31'd0, protocol_err}, {31'd0, perr_model});
          exp_last = cur ? (rq1.size() > 0 && rq1[0].last) : (rq0.size() > 0 && rq0[0].last);
          if ((s_rlast != exp_last) || (s_rid != {3'd0, cur})) perr_model = 1;
        end

        if (m0_rvalid | m1_rvalid) check("one_rvalid", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);

        if (m0_rvalid & m0_rready) begin
          m0_beats++;
          if (rq0.size() == 0) check("m0_beat_unexpected", 32'd1, 32'd0);
          else begin
            b = rq0.pop_front();
            check("m0_rdata", m0_rdata, b.data);
            check("m0_rresp", {30'd0, m0_rresp}, {30'd0, b.resp});
            check("m0_rlast", {31'd0, m0_rlast}, {31'd0, b.last});
            if (b.last) chk_idle = 1;
          end
        end
        if (m1_rvalid & m1_rready) begin
          if (rq1.size() == 0) check("m1_beat_unexpected", 32'd1, 32'd0);
          else begin
            b = rq1.pop_front();
            check("m1_rdata", m1_rdata, b.data);
            check("m1_rresp", {30'd0, m1_rresp}, {30'd0, b.resp});
            if (b.last) chk_idle = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push0(input logic [31:0] addr, input logic [3:0] len);
    req_t r;
    r.addr = addr; r.len = len; r.size = 3'($urandom_range(0, 2)); r.burst = 2'($urandom_range(0, 2));
    q0.push_back(r);
  endtask

  task automatic push1(input logic [31:0] addr);
    req_t r;
    r.addr = addr; r.len = 4'd0; r.size = 3'($urandom_range(0, 2)); r.burst = 2'b00;
    q1.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      if (q0.size() == 0 && q1.size() == 0 && rq0.size() == 0 && rq1.size() == 0 &&
          ar_q.size() == 0 && !busy && !m0_arvalid && !m1_arvalid) ok = 1;
    end
    if (!ok) $display("FAIL timeout %s", name);
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int start;
    bit ok;
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_s_arvalid", {31'd0, s_arvalid}, 32'd0);
    check("rst_perr", {31'd0, protocol_err}, 32'd0);
    check("rst_s_arid", {28'd0, s_arid}, 32'd0);
    @(posedge clock); #3 reset = 0;

    // Simultaneous requests right after reset: m0 first, then m1.
    @(negedge clock);
    push0(32'h1000_0000, 4'd1);
    push1(32'h2000_0040);
    wait_idle("simul");
    check("simul_id0", (ar_ids.size() > 0) ? {28'd0, ar_ids[0]} : 32'hFFFF_FFFF, 32'd0);
    check("simul_id1", (ar_ids.size() > 1) ? {28'd0, ar_ids[1]} : 32'hFFFF_FFFF, 32'd1);

    // Single m0 burst of 4 beats.
    push0(32'h3000_0000, 4'd3);
    wait_idle("single");

    // m0 continuously requesting, m1 arrives during an m0 burst.
    for (int i = 0; i < 3; i++) push0(32'h4000_0000 + 32'(i * 64), 4'd2);
    repeat (6) @(negedge clock);
    push1(32'h5000_0000);
    push1(32'h5000_0004);
    wait_idle("fair");

    // Randomised traffic.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) push0($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) push1($urandom & 32'hFFFF_FFFC);
      repeat ($urandom_range(0, 12)) @(negedge clock);
    end
    wait_idle("random");

    // Requester drops rready for 5 cycles with downstream rvalid held high.
    force_rvalid = 1;
    start = m0_beats;
    push0(32'h6000_0000, 4'd7);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      if (m0_beats >= start + 2) ok = 1;
    end
    check("stall_reach", {31'd0, ok}, 32'd1);
    stall0 = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_s_rready", {31'd0, s_rready}, 32'd0);
      check("stall_rvalid", {31'd0, m0_rvalid}, 32'd1);
    end
    force_rvalid = 0;
    wait_idle("stall");

    // Early rlast from downstream.
    check("perr_clean", {31'd0, protocol_err}, 32'd0);
    early_mode = 1;
    push0(32'h7000_0000, 4'd3);
    wait_idle("early");
    early_mode = 0;
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    push1(32'h7000_1000);
    wait_idle("after_early");
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);

    // Reset in the middle of a data phase.
    start = m0_beats;
    push0(32'h8000_0000, 4'd15);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clock);
      if (m0_beats > start) ok = 1;
    end
    check("mid_reach", {31'd0, ok}, 32'd1);
    @(posedge clock); #3 reset = 1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_s_rready", {31'd0, s_rready}, 32'd0);
    check("arst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check("arst_m0_rdata", m0_rdata, 32'd0);
    check("arst_perr", {31'd0, protocol_err}, 32'd0);
    check("arst_s_araddr", s_araddr, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset = 0;
    @(negedge clock);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    ar_ids.delete();
    push1(32'h9000_0010);
    wait_idle("post_reset");
    check("post_rst_id", (ar_ids.size() == 1) ? {28'd0, ar_ids[0]} : 32'hFFFF_FFFF, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
